// File: rtl/stream_unpacker.sv
// stream_unpacker: AXI4-Stream video sink.
// Rebuilds 24-bit RGB pixels (byte 0 = r, byte 1 = g, byte 2 = b) from a
// 32-bit packed byte stream, tags each pixel with x/y coordinates and checks
// frame (tuser = SOF) and line (tlast = EOL) framing.
// Optional feature macro: STREAM_UNPACKER_ERR_CNT_EN adds a saturating
// framing-error counter (err_count) with a synchronous clear (err_clr).
module stream_unpacker #(
  parameter int X_SIZE = 640,
  parameter int Y_SIZE = 480
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] in_stream_tdata,
  input  logic [3:0]  in_stream_tkeep,
  input  logic        in_stream_tlast,
  input  logic        in_stream_tuser,
  input  logic        in_stream_tvalid,
  output logic        in_stream_tready,
  output logic [7:0]  pix_r,
  output logic [7:0]  pix_g,
  output logic [7:0]  pix_b,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        err_sof,
  output logic        err_eol,
  output logic        frame_done
`ifdef STREAM_UNPACKER_ERR_CNT_EN
  ,
  output logic [15:0] err_count,
  input  logic        err_clr
`endif
);

  localparam int WPL  = X_SIZE * 3 / 4;
  localparam int WX_W = (WPL > 1) ? $clog2(WPL) : 1;

  // Output pixel register contents.
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [9:0] x;
    logic [8:0] y;
    logic       sof;
    logic       eol;
  } pix_t;

  // Byte keep is not used: every byte of an accepted word is valid.
  logic unused_tkeep;
  assign unused_tkeep = ^in_stream_tkeep;

  // State
  logic [7:0]      buf_q [6];
  logic [7:0]      buf_d [6];
  logic [2:0]      count_q, count_d;
  logic            tready_q, tready_d;
  logic [WX_W-1:0] wx_q, wx_d;
  logic [8:0]      wy_q, wy_d;
  logic [9:0]      px_q, px_d;
  logic [8:0]      py_q, py_d;
  logic            expect_sof_q, expect_sof_d;
  pix_t            pix_q, pix_d;
  logic            pix_valid_q, pix_valid_d;
  logic            err_sof_q, err_sof_d;
  logic            err_eol_q, err_eol_d;

  // Datapath intermediates
  logic            accept;
  logic            sof_word;
  logic            pop;
  logic            early_eol;
  logic            last_word;
  logic [3:0]      base_cnt;
  logic [3:0]      avail;
  logic [7:0]      wbyte [4];
  logic [7:0]      cat   [10];
  logic [WX_W-1:0] wx_e;
  logic [8:0]      wy_e;
  logic [9:0]      px_e;
  logic [8:0]      py_e;

  assign accept   = in_stream_tvalid & tready_q;
  assign sof_word = accept & in_stream_tuser;

  // Split the incoming word into stream-ordered bytes.
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      wbyte[j] = in_stream_tdata[8*j +: 8];
    end
  end

  // Line up buffered bytes (oldest first) followed by the accepted word, pop
  // one pixel when possible and update the word/pixel counters and checks.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    buf_d        = buf_q;
    count_d      = count_q;
    wx_d         = wx_q;
    wy_d         = wy_q;
    px_d         = px_q;
    py_d         = py_q;
    expect_sof_d = expect_sof_q;
    pix_d        = pix_q;
    pix_valid_d  = pix_valid_q;
    err_sof_d    = 1'b0;
    err_eol_d    = 1'b0;
    early_eol    = 1'b0;
    last_word    = 1'b0;

    // A start-of-frame word restarts every counter and drops stale bytes.
    wx_e     = sof_word ? '0 : wx_q;
    wy_e     = sof_word ? '0 : wy_q;
    px_e     = sof_word ? '0 : px_q;
    py_e     = sof_word ? '0 : py_q;
    base_cnt = sof_word ? 4'd0 : {1'b0, count_q};
    avail    = base_cnt + (accept ? 4'd4 : 4'd0);

    for (int i = 0; i < 10; i++) begin
      cat[i] = 8'h00;
    end
    for (int i = 0; i < 6; i++) begin
      if (i < int'(base_cnt)) cat[i] = buf_q[i];
    end
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 10; i++) begin
        if (accept && (i == int'(base_cnt) + j)) cat[i] = wbyte[j];
      end
    end

    pop = (avail >= 4'd3) && (!pix_valid_q || pix_ready);

    for (int i = 0; i < 6; i++) begin
      buf_d[i] = pop ? cat[i+3] : cat[i];
    end
    count_d = 3'(avail - (pop ? 4'd3 : 4'd0));

    // Output register: load on pop, clear once taken, otherwise hold.
    if (pop) begin
      pix_valid_d = 1'b1;
      pix_d.r     = cat[0];
      pix_d.g     = cat[1];
      pix_d.b     = cat[2];
      pix_d.x     = px_e;
      pix_d.y     = py_e;
      pix_d.sof   = (px_e == '0) && (py_e == '0);
      pix_d.eol   = (px_e == 10'(X_SIZE - 1));
      if (px_e == 10'(X_SIZE - 1)) begin
        px_d = '0;
        py_d = (py_e == 9'(Y_SIZE - 1)) ? '0 : py_e + 9'd1;
      end else begin
        px_d = px_e + 10'd1;
        py_d = py_e;
      end
    end else begin
      px_d = px_e;
      py_d = py_e;
      if (pix_ready) pix_valid_d = 1'b0;
    end

    // Framing checks and word counters for an accepted word.
    if (accept) begin
      last_word = (wx_e == WX_W'(WPL - 1));
      early_eol = in_stream_tlast && !last_word;
      err_sof_d = (in_stream_tuser && ((wx_q != '0) || (wy_q != '0))) ||
                  (expect_sof_q && !in_stream_tuser);
      err_eol_d = early_eol || (last_word && !in_stream_tlast);

      if (last_word || early_eol) begin
        wx_d         = '0;
        wy_d         = (wy_e == 9'(Y_SIZE - 1)) ? '0 : wy_e + 9'd1;
        expect_sof_d = (wy_e == 9'(Y_SIZE - 1));
      end else begin
        wx_d         = wx_e + 1'b1;
        wy_d         = wy_e;
        expect_sof_d = 1'b0;
      end

      // An early tlast closes the line: leftovers are dropped and the pixel
      // position jumps to the start of the next line.
      if (early_eol) begin
        count_d = '0;
        px_d    = '0;
        py_d    = (py_e == 9'(Y_SIZE - 1)) ? '0 : py_e + 9'd1;
      end
    end

    tready_d = (count_d <= 3'd2);
  end

  // Control state, counters and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before this edge.
    if (rst_i) begin
      count_q      <= '0;
      tready_q     <= 1'b0;
      wx_q         <= '0;
      wy_q         <= '0;
      px_q         <= '0;
      py_q         <= '0;
      expect_sof_q <= 1'b1;
      pix_q        <= '0;
      pix_valid_q  <= 1'b0;
      err_sof_q    <= 1'b0;
      err_eol_q    <= 1'b0;
    end else begin
      count_q      <= count_d;
      tready_q     <= tready_d;
      wx_q         <= wx_d;
      wy_q         <= wy_d;
      px_q         <= px_d;
      py_q         <= py_d;
      expect_sof_q <= expect_sof_d;
      pix_q        <= pix_d;
      pix_valid_q  <= pix_valid_d;
      err_sof_q    <= err_sof_d;
      err_eol_q    <= err_eol_d;
    end
  end

  // Byte buffer storage.
  always_ff @(posedge clk_i) begin
    // NOTE: the buffer bytes are not reset; count_q alone marks which ones
    // hold data, so stale contents are never observed.
    buf_q <= buf_d;
  end

`ifdef STREAM_UNPACKER_ERR_CNT_EN
  logic [15:0] err_count_q, err_count_d;

  // Saturating framing-error counter; clear takes priority.
  always_comb begin
    err_count_d = err_count_q;
    if (err_clr) begin
      err_count_d = '0;
    end else if ((err_sof_q || err_eol_q) && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  // Error counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_count_q <= '0;
    else       err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`endif

  assign in_stream_tready = tready_q;
  assign pix_r            = pix_q.r;
  assign pix_g            = pix_q.g;
  assign pix_b            = pix_q.b;
  assign pix_x            = pix_q.x;
  assign pix_y            = pix_q.y;
  assign pix_sof          = pix_q.sof;
  assign pix_eol          = pix_q.eol;
  assign pix_valid        = pix_valid_q;
  assign err_sof          = err_sof_q;
  assign err_eol          = err_eol_q;
  assign frame_done       = pix_valid_q & pix_ready & pix_q.eol &
                            (pix_q.y == 9'(Y_SIZE - 1));

endmodule

// File: tb/tb_stream_unpacker.sv
// tb_stream_unpacker: scoreboard bench for stream_unpacker on a small
// 16x4 frame. Expected pixels are queued as words are generated and compared
// whenever the DUT presents a pixel.
module tb_stream_unpacker;

  localparam int X   = 16;
  localparam int Y   = 4;
  localparam int WPL = X * 3 / 4;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [9:0] x;
    logic [8:0] y;
    logic       sof;
    logic       eol;
    logic       fd;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast, tuser, tvalid, tready;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic        pix_sof, pix_eol, pix_valid, pix_ready;
  logic        err_sof, err_eol, frame_done;
`ifdef STREAM_UNPACKER_ERR_CNT_EN
  logic [15:0] err_count;
  logic        err_clr;
`endif

  exp_t       exp_q[$];
  logic [7:0] preset_q[$];
  int checks, failures;
  int sof_pulses, eol_pulses, err_cycles;
  int exp_sof, exp_eol;

  stream_unpacker #(.X_SIZE(X), .Y_SIZE(Y)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .in_stream_tdata  (tdata),
    .in_stream_tkeep  (tkeep),
    .in_stream_tlast  (tlast),
    .in_stream_tuser  (tuser),
    .in_stream_tvalid (tvalid),
    .in_stream_tready (tready),
    .pix_r            (pix_r),
    .pix_g            (pix_g),
    .pix_b            (pix_b),
    .pix_x            (pix_x),
    .pix_y            (pix_y),
    .pix_sof          (pix_sof),
    .pix_eol          (pix_eol),
    .pix_valid        (pix_valid),
    .pix_ready        (pix_ready),
    .err_sof          (err_sof),
    .err_eol          (err_eol),
    .frame_done       (frame_done)
`ifdef STREAM_UNPACKER_ERR_CNT_EN
    ,
    .err_count        (err_count),
    .err_clr          (err_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Scoreboard monitor: every presented pixel must match the queue head
  // (this also covers holding while stalled); pop on handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (err_sof) sof_pulses++;
      if (err_eol) eol_pulses++;
      if (err_sof || err_eol) err_cycles++;
      if (pix_valid) begin
        if (exp_q.size() == 0) begin
          check("pix_unexpected", {63'd0, pix_valid}, 64'd0);
        end else begin
          check("pix", {18'd0, pix_r, pix_g, pix_b, pix_x, pix_y, pix_sof, pix_eol, frame_done},
                {18'd0, exp_q[0]});
          if (pix_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  function automatic logic [7:0] next_byte();
    if (preset_q.size() != 0) return preset_q.pop_front();
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic send_word(input logic [31:0] d, input logic u, input logic l);
    int n;
    n = 0;
    tdata = d; tuser = u; tlast = l; tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (tready) begin
        @(posedge clk);
        #1;
        break;
      end
      n++;
      if (n > 500) begin
        check("tready_timeout", {63'd0, tready}, 64'd1);
        break;
      end
    end
    tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
  endtask

  // Send nwords of random bytes for line y; queue the complete pixels they form.
  task automatic send_line(input int nwords, input bit user0, input bit last_final, input int y);
    logic [7:0] b[$];
    exp_t e;
    for (int i = 0; i < 4 * nwords; i++) b.push_back(next_byte());
    for (int k = 0; k < (4 * nwords) / 3; k++) begin
      e.r   = b[3*k];
      e.g   = b[3*k+1];
      e.b   = b[3*k+2];
      e.x   = 10'(k);
      e.y   = 9'(y);
      e.sof = (k == 0) && (y == 0);
      e.eol = (k == X - 1);
      e.fd  = (k == X - 1) && (y == Y - 1);
      exp_q.push_back(e);
    end
    for (int w = 0; w < nwords; w++) begin
      send_word({b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]}, user0 && (w == 0),
                last_final && (w == nwords - 1));
    end
  endtask

  task automatic send_frame(input bit user, input int no_tlast_line);
    for (int y = 0; y < Y; y++) send_line(WPL, user && (y == 0), y != no_tlast_line, y);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_err_sof"}, 64'(sof_pulses), 64'(exp_sof));
    check({tag, "_err_eol"}, 64'(eol_pulses), 64'(exp_eol));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0;
    sof_pulses = 0; eol_pulses = 0; err_cycles = 0;
    exp_sof = 0; exp_eol = 0;
    rst = 1'b1; tdata = '0; tkeep = 4'hF; tlast = 1'b0; tuser = 1'b0; tvalid = 1'b0;
    pix_ready = 1'b1;
`ifdef STREAM_UNPACKER_ERR_CNT_EN
    err_clr = 1'b0;
`endif

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_tready", {63'd0, tready}, 64'd0);
    check("rst_valid", {63'd0, pix_valid}, 64'd0);
    check("rst_errs", {62'd0, err_sof, err_eol}, 64'd0);
    check("rst_pix", {30'd0, pix_r, pix_g, pix_b, pix_x}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_tready", {63'd0, tready}, 64'd1);

    // Frame 1: known first three words, clean framing.
    preset_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
    send_frame(1'b1, -1);
    drain("frame1");

    // Frame 2 with a 10-cycle downstream stall mid-line.
    fork
      send_frame(1'b1, -1);
      begin
        repeat (20) @(posedge clk);
        #1 pix_ready = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("stall_tready", {63'd0, tready}, 64'd0);
        check("stall_valid", {63'd0, pix_valid}, 64'd1);
        @(posedge clk);
        #1 pix_ready = 1'b1;
      end
    join
    drain("stall");

    // Early tlast on word 4 of line 0: two leftover bytes dropped, next is (0,1).
    send_line(5, 1'b1, 1'b1, 0);
    for (int y = 1; y < Y; y++) send_line(WPL, 1'b0, 1'b1, y);
    exp_eol++;
    drain("early_eol");

    // tuser on word 5 of line 2: restart at (0,0).
    send_line(WPL, 1'b1, 1'b1, 0);
    send_line(WPL, 1'b0, 1'b1, 1);
    send_line(5, 1'b0, 1'b0, 2);
    send_frame(1'b1, -1);
    exp_sof++;
    drain("mid_sof");

    // Missing tlast at the end of line 1: flagged, counting unaffected.
    send_frame(1'b1, 1);
    exp_eol++;
    drain("miss_eol");

    // Reset mid-line while a pixel is held on the output.
    pix_ready = 1'b0;
    begin
      exp_t e;
      e = '{r: 8'h11, g: 8'h22, b: 8'h33, x: 10'd0, y: 9'd0, sof: 1'b1, eol: 1'b0, fd: 1'b0};
      exp_q.push_back(e);
    end
    send_word(32'h44332211, 1'b1, 1'b0);
    send_word(32'h88776655, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_rst_valid", {63'd0, pix_valid}, 64'd0);
    check("async_rst_tready", {63'd0, tready}, 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    pix_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rerst_tready", {63'd0, tready}, 64'd1);
    check("rerst_valid", {63'd0, pix_valid}, 64'd0);

    // First frame after reset lacks tuser: flagged, data still processed.
    send_frame(1'b0, -1);
    exp_sof++;
    drain("no_sof");

`ifdef STREAM_UNPACKER_ERR_CNT_EN
    check("err_count", {48'd0, err_count}, 64'(err_cycles));
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    check("err_count_clr", {48'd0, err_count}, 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
